// File: rtl/axi4lite_cmd_master_if.sv
// Bundles the command/response handshake and the AXI4-Lite channels of the command master.
// The master modport is the RTL view; the slave modport is the command source plus bus slave.
interface axi4lite_cmd_master_if #(
  parameter int ADDR_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rnw;
  logic [1:0]        cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_status;
  logic [1:0]        rsp_resp;
  logic [31:0]       rsp_rdata;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output cmd_ready, rsp_valid, rsp_status, rsp_resp, rsp_rdata,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  cmd_ready, rsp_valid, rsp_status, rsp_resp, rsp_rdata,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready
  );
endinterface

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: runs one sized read/write command per response,
// aborting with TIMEOUT status if the slave does not finish within TIMEOUT_CYCLES.
module axi4lite_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  clk,
  input logic                  rst,
  axi4lite_cmd_master_if.master bus
);
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_SINGLE, SZ_DOUBLE} size_e;
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_e;

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  size_e             size_q, size_d;
  logic [1:0]        alo_q, alo_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_status_q, rsp_status_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, expire, abort;

  function automatic logic [31:0] extract(size_e sz, logic [1:0] a, logic [31:0] d);
    logic [31:0] shifted;
    shifted = d >> {a, 3'b000};
    case (sz)
      SZ_BYTE: return {24'b0, shifted[7:0]};
      SZ_HALF: return a[1] ? {16'b0, d[31:16]} : {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign aw_hs  = awvalid_q & bus.awready;
  assign w_hs   = wvalid_q & bus.wready;
  assign b_hs   = bready_q & bus.bvalid;
  assign ar_hs  = arvalid_q & bus.arready;
  assign r_hs   = rready_q & bus.rvalid;
  assign expire = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path can infer a latch.
    state_d      = state_q;
    timer_d      = timer_q + TMR_W'(1);
    size_d       = size_q;
    alo_d        = alo_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_resp_d   = rsp_resp_q;
    rsp_rdata_d  = rsp_rdata_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bus.cmd_valid) begin
          size_d = size_e'(bus.cmd_size);
          alo_d  = bus.cmd_addr[1:0];
          if (bus.cmd_rnw) begin
            araddr_d  = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end else begin
            awaddr_d  = bus.cmd_addr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
            case (size_e'(bus.cmd_size))
              SZ_BYTE: begin
                wstrb_d = 4'b0001 << bus.cmd_addr[1:0];
                wdata_d = {4{bus.cmd_wdata[7:0]}};
              end
              SZ_HALF: begin
                wstrb_d = bus.cmd_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.cmd_wdata[15:0]}};
              end
              default: begin
                wstrb_d = 4'b1111;
                wdata_d = bus.cmd_wdata;
              end
            endcase
          end
        end
      end
      WR_AW_W: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (expire) begin
          abort = 1'b1;
        end else if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (b_hs) begin
          bready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = 1'b0;
          rsp_resp_d   = bus.bresp;
          rsp_rdata_d  = '0;
          state_d      = RSP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_R: begin
        if (r_hs) begin
          rready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = 1'b0;
          rsp_resp_d   = bus.rresp;
          rsp_rdata_d  = extract(size_q, alo_q, bus.rdata);
          state_d      = RSP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Valids are withdrawn on timeout so a hung slave cannot stall the command source.
    if (abort) begin
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      rsp_valid_d  = 1'b1;
      rsp_status_d = 1'b1;
      rsp_resp_d   = 2'b00;
      rsp_rdata_d  = '0;
      state_d      = RSP;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, since they drive bus outputs that must read 0.
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      size_q       <= SZ_BYTE;
      alo_q        <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 1'b0;
      rsp_resp_q   <= '0;
      rsp_rdata_q  <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q      <= state_d;
      timer_q      <= timer_d;
      size_q       <= size_d;
      alo_q        <= alo_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_resp_q   <= rsp_resp_d;
      rsp_rdata_q  <= rsp_rdata_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_resp   = rsp_resp_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.awaddr     = awaddr_q;
  assign bus.awprot     = 3'b000;
  assign bus.awvalid    = awvalid_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.wvalid     = wvalid_q;
  assign bus.bready     = bready_q;
  assign bus.araddr     = araddr_q;
  assign bus.arprot     = 3'b000;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed bench for axi4lite_cmd_master: hand-computed expectations for sized writes/reads,
// slave back-pressure, timeout, response hold-off and mid-transaction reset.
module tb_axi4lite_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  axi4lite_cmd_master_if #(.ADDR_W(32)) bus ();

  axi4lite_cmd_master #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rnw, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd);
    bus.cmd_rnw   = rnw;
    bus.cmd_size  = sz;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic seen_rsp;

    bus.cmd_valid = 0; bus.cmd_rnw = 0; bus.cmd_size = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.rsp_ready = 0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;
    bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("reset rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_resp}, 0);
    check("reset rsp_rdata", bus.rsp_rdata, 0);

    // Write SINGLE, zero-wait slave
    bus.awready = 1; bus.wready = 1; bus.bvalid = 1; bus.bresp = 2'b00;
    send(0, 2'd2, 32'h10, 32'hDEADBEEF);
    check("w1 awvalid", bus.awvalid, 1);
    check("w1 wvalid", bus.wvalid, 1);
    check("w1 cmd_ready", bus.cmd_ready, 0);
    check("w1 awaddr", bus.awaddr, 32'h10);
    check("w1 wstrb", bus.wstrb, 4'hF);
    check("w1 wdata", bus.wdata, 32'hDEADBEEF);
    tick();
    check("w1 aw/w dropped", {bus.awvalid, bus.wvalid}, 0);
    check("w1 bready", bus.bready, 1);
    check("w1 rsp not yet", bus.rsp_valid, 0);
    tick();
    check("w1 rsp_valid N+3", bus.rsp_valid, 1);
    check("w1 bready dropped", bus.bready, 0);
    check("w1 status/resp", {bus.rsp_status, bus.rsp_resp}, 0);
    check("w1 rdata", bus.rsp_rdata, 0);
    ack_rsp();
    check("w1 rsp cleared", bus.rsp_valid, 0);
    check("w1 cmd_ready back", bus.cmd_ready, 1);

    // Write BYTE at 0x13, AW ready late, W immediate, bresp 01
    bus.awready = 0; bus.bresp = 2'b01;
    send(0, 2'd0, 32'h13, 32'h000000A5);
    check("w2 wstrb", bus.wstrb, 4'b1000);
    check("w2 wdata", bus.wdata, 32'hA5A5A5A5);
    tick();
    check("w2 wvalid dropped", bus.wvalid, 0);
    check("w2 awvalid held", bus.awvalid, 1);
    tick();
    check("w2 awvalid still", bus.awvalid, 1);
    bus.awready = 1;
    tick();
    check("w2 awvalid dropped", bus.awvalid, 0);
    check("w2 bready", bus.bready, 1);
    wait_rsp(n);
    check("w2 b latency", n, 1);
    check("w2 status/resp", {bus.rsp_status, bus.rsp_resp}, 3'b001);
    ack_rsp();

    // HALFWORD write at 0x22
    send(0, 2'd1, 32'h22, 32'h0000BEEF);
    check("w3 wstrb", bus.wstrb, 4'b1100);
    check("w3 wdata", bus.wdata, 32'hBEEFBEEF);
    wait_rsp(n);
    ack_rsp();

    // Read HALFWORD at 0x22, rresp 10
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'h12345678; bus.rresp = 2'b10;
    send(1, 2'd1, 32'h22, 32'h0);
    check("r1 arvalid", bus.arvalid, 1);
    check("r1 araddr", bus.araddr, 32'h22);
    tick();
    check("r1 arvalid dropped", bus.arvalid, 0);
    check("r1 rready", bus.rready, 1);
    tick();
    check("r1 rsp_valid", bus.rsp_valid, 1);
    check("r1 rsp_rdata", bus.rsp_rdata, 32'h00001234);
    check("r1 status/resp", {bus.rsp_status, bus.rsp_resp}, 3'b010);
    ack_rsp();

    // Read BYTE at 0x21 -> byte lane 1
    send(1, 2'd0, 32'h21, 32'h0);
    wait_rsp(n);
    check("r2 latency", n, 2);
    check("r2 rsp_rdata", bus.rsp_rdata, 32'h00000056);
    ack_rsp();

    // Read with arready never asserted -> timeout
    bus.arready = 0; bus.rvalid = 0;
    send(1, 2'd2, 32'h30, 32'h0);
    repeat (7) tick();
    check("to arvalid at N+8", bus.arvalid, 1);
    check("to no early rsp", bus.rsp_valid, 0);
    tick();
    check("to arvalid at N+9", bus.arvalid, 0);
    check("to rsp_valid", bus.rsp_valid, 1);
    check("to status/resp", {bus.rsp_status, bus.rsp_resp}, 3'b100);
    check("to rsp_rdata", bus.rsp_rdata, 0);
    check("to readies", {bus.rready, bus.bready}, 0);
    ack_rsp();

    // R handshake on the expiry cycle wins
    bus.arready = 1;
    send(1, 2'd3, 32'h40, 32'h0);
    repeat (7) tick();
    check("ex rready", bus.rready, 1);
    check("ex no rsp yet", bus.rsp_valid, 0);
    bus.rvalid = 1; bus.rdata = 32'hCAFEF00D; bus.rresp = 2'b01;
    tick();
    bus.rvalid = 0;
    check("ex rsp_valid", bus.rsp_valid, 1);
    check("ex status/resp", {bus.rsp_status, bus.rsp_resp}, 3'b001);
    check("ex rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    ack_rsp();

    // Response held off for 5 cycles with a second command pending
    bus.awready = 1; bus.wready = 1; bus.bvalid = 1; bus.bresp = 2'b11;
    send(0, 2'd2, 32'h44, 32'h0);
    wait_rsp(n);
    check("hold latency", n, 2);
    bus.cmd_rnw = 0; bus.cmd_size = 2'd2; bus.cmd_addr = 32'h50; bus.cmd_wdata = 32'h11223344;
    bus.cmd_valid = 1; bus.bresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold rsp_valid", bus.rsp_valid, 1);
      check("hold rsp_resp", bus.rsp_resp, 2'b11);
      check("hold cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    check("hold rsp dropped", bus.rsp_valid, 0);
    check("hold cmd_ready", bus.cmd_ready, 1);
    check("hold not accepted", bus.awvalid, 0);
    tick();
    bus.cmd_valid = 0;
    check("hold accepted", bus.awvalid, 1);
    check("hold awaddr", bus.awaddr, 32'h50);
    wait_rsp(n);
    check("hold 2nd resp", bus.rsp_resp, 2'b00);
    ack_rsp();

    // Reset while waiting in WR_B
    bus.bvalid = 0;
    send(0, 2'd2, 32'h60, 32'h55AA55AA);
    tick();
    check("rst bready before", bus.bready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("rst cmd_ready", bus.cmd_ready, 1);
    check("rst awaddr", bus.awaddr, 0);
    check("rst wdata/wstrb", {bus.wdata[27:0], bus.wstrb}, 0);
    bus.bvalid = 1;
    seen_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_rsp = seen_rsp | bus.rsp_valid;
    end
    check("rst no rsp pulse", seen_rsp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
